// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end.
// Owns the fetch PC, issues pipelined ibus requests and buffers returned
// instructions with their PCs in an in-order queue popped by decode.
//
// state | meaning
// IDLE  | no request presented on the ibus
// HOLD  | request at req_addr presented, waiting for iresp_addr_ok
//
// Credit: a new request is issued only when every queue slot can absorb all
// accepted requests plus the new one. Issue also requires that fewer than
// MAX_INFLIGHT requests were outstanding at the start of the cycle. A held
// request accepted in the same cycle counts as outstanding, so up to
// MAX_INFLIGHT+1 requests can be accepted at once. The PC FIFO is sized for
// that maximum.
module fetch_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter logic [31:0] RESET_PC     = 32'hbfc0_0000
) (
   input  logic                         clk,
   input  logic                         resetn,
   output logic                         ireq_valid,
   output logic [31:0]                  ireq_addr,
   input  logic                         iresp_addr_ok,
   input  logic                         iresp_data_ok,
   input  logic [31:0]                  iresp_data,
   input  logic                         redir_valid,
   input  logic [31:0]                  redir_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [31:0]                  out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PD = MAX_INFLIGHT + 1;
   localparam int PW = $clog2(PD);
   localparam int OW = $clog2(MAX_INFLIGHT + 2);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state, state_n;
   logic [31:0]    fpc, fpc_n;
   logic [31:0]    req_addr, req_addr_n;
   logic [OW-1:0]  outst, outst_n;
   logic [OW-1:0]  drop_cnt, drop_n;
   logic [CW-1:0]  count_n;

   logic [63:0]    q_mem [DEPTH];
   logic [AW-1:0]  q_rd, q_wr;
   logic [31:0]    pc_mem [PD];
   logic [PW-1:0]  pc_rd, pc_wr;

   logic           accept, resp, drop, push, pop, full, credit_ok;

   assign accept    = (state == HOLD) && iresp_addr_ok;
   assign resp      = iresp_data_ok && (outst != '0);
   assign drop      = resp && (drop_cnt != '0);
   assign push      = resp && (drop_cnt == '0) && !redir_valid;
   assign pop       = out_valid && out_ready;
   assign full      = (count == CW'(DEPTH));
   assign outst_n   = outst + OW'(accept) - OW'(resp);
   assign count_n   = redir_valid ? '0 : count + CW'(push) - CW'(pop);
   assign credit_ok = (int'(count_n) + int'(outst_n) < int'(DEPTH)) &&
                      (outst < OW'(MAX_INFLIGHT));

   assign ireq_valid = (state == HOLD);
   assign ireq_addr  = req_addr;
   assign out_valid  = (count != '0);
   assign out_pc     = q_mem[q_rd][63:32];
   assign out_instr  = q_mem[q_rd][31:0];

   // Request FSM next state, fetch PC advance and stale-response accounting.
   always_comb begin
      state_n    = state;
      fpc_n      = fpc;
      req_addr_n = req_addr;
      drop_n     = drop_cnt - OW'(drop);
      if (redir_valid) begin
         // A held request cannot be withdrawn; its response becomes stale too.
         fpc_n = redir_pc;
         if ((state == HOLD) && !iresp_addr_ok) begin
            state_n = HOLD;
            drop_n  = outst_n + OW'(1);
         end else begin
            state_n = IDLE;
            drop_n  = outst_n;
         end
      end else if (((state == IDLE) || accept) && credit_ok) begin
         state_n    = HOLD;
         req_addr_n = fpc;
         fpc_n      = fpc + 32'd4;
      end else if (accept) begin
         state_n = IDLE;
      end
   end

   // Request FSM and fetch bookkeeping registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         req_addr <= RESET_PC;
         outst    <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_n;
         fpc      <= fpc_n;
         req_addr <= req_addr_n;
         outst    <= outst_n;
         drop_cnt <= drop_n;
      end
   end

   // Instruction queue pointers and occupancy; redirect empties it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_rd  <= '0;
         q_wr  <= '0;
         count <= '0;
      end else if (redir_valid) begin
         q_rd  <= '0;
         q_wr  <= '0;
         count <= '0;
      end else begin
         if (push) q_wr <= q_wr + AW'(1);
         if (pop)  q_rd <= q_rd + AW'(1);
         count <= count_n;
      end
   end

   // Instruction queue storage.
   always_ff @(posedge clk) begin
      if (push) q_mem[q_wr] <= {pc_mem[pc_rd], iresp_data};
   end

   // PC FIFO pointers: one entry per accepted request, retired on its response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_rd <= '0;
         pc_wr <= '0;
      end else begin
         if (accept) pc_wr <= (pc_wr == PW'(PD - 1)) ? '0 : pc_wr + PW'(1);
         if (resp)   pc_rd <= (pc_rd == PW'(PD - 1)) ? '0 : pc_rd + PW'(1);
      end
   end

   // PC FIFO storage.
   always_ff @(posedge clk) begin
      if (accept) pc_mem[pc_wr] <= req_addr;
   end

   // The credit rule must keep pushes away from a full queue.
   always_ff @(posedge clk) begin
      if (resetn) assert (!(push && full && !pop));
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ibus responder, queue/PC reference model,
// directed sequences, a phase table and a randomized run.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int MAX_INFLIGHT = 2;
   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   logic        clk, resetn;
   logic        ireq_valid, iresp_addr_ok, iresp_data_ok, redir_valid;
   logic        out_valid, out_ready;
   logic [31:0] ireq_addr, iresp_data, redir_pc, out_instr, out_pc;
   logic [2:0]  count;

   fetch_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .resetn(resetn),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .count(count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {logic [31:0] addr; bit keep; int cyc;} bus_t;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   typedef struct {int ready; int ok; int cycles; int exp_count; bit exp_ivalid; int exp_acc;} vec_t;

   bus_t        bus_q[$];
   ent_t        exp_q[$];
   logic [31:0] acc_log[$];

   int checks = 0, failures = 0;
   int cyc = 0, accepts = 0, pops = 0, data_cnt = 0;
   int k_ready, k_ok, k_data, k_lat, k_redir_prob;
   bit k_redir_once;
   logic [31:0] k_rpc, next_pc, stale_addr;
   bit stale_valid;

   function automatic logic [31:0] instr_of(logic [31:0] a);
      return (a * 32'h9e37_79b9) ^ 32'h0bad_f00d;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, want);
      end
   endfunction

   function automatic void timeout(string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endfunction

   task automatic do_reset();
      resetn = 1'b0;
      out_ready = 0; iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
      redir_valid = 0; redir_pc = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ireq_valid", ireq_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      resetn = 1'b1;
      bus_q.delete(); exp_q.delete(); acc_log.delete();
      stale_valid = 0; next_pc = RESET_PC;
      accepts = 0; pops = 0; data_cnt = 0;
      k_redir_once = 0; k_redir_prob = 0;
   endtask

   // One clock: drive bus/decode inputs, then update the model and compare.
   task automatic tick();
      logic [31:0] r, c_addr, c_rpc;
      bit c_acc, c_data, c_pop, c_redir, c_stay, keep;
      bus_t b;
      out_ready = ($urandom_range(99) < k_ready);
      iresp_addr_ok = ireq_valid && ($urandom_range(99) < k_ok);
      iresp_data_ok = 0;
      iresp_data = $urandom;
      if (bus_q.size() > 0 && (cyc + 1 - bus_q[0].cyc >= k_lat) && ($urandom_range(99) < k_data)) begin
         iresp_data_ok = 1;
         iresp_data = instr_of(bus_q[0].addr);
      end
      redir_valid = 0;
      redir_pc = $urandom;
      if (k_redir_once) begin
         redir_valid = 1; redir_pc = k_rpc; k_redir_once = 0;
      end else if ($urandom_range(999) < k_redir_prob) begin
         r = $urandom;
         redir_valid = 1;
         redir_pc = ($urandom_range(3) == 0) ? 32'hffff_fff0 + {r[3:2], 2'b00} : {r[31:2], 2'b00};
      end
      c_acc = ireq_valid && iresp_addr_ok;  c_addr = ireq_addr;
      c_data = iresp_data_ok;               c_pop = out_valid && out_ready;
      c_redir = redir_valid;                c_rpc = redir_pc;
      c_stay = ireq_valid && !iresp_addr_ok;
      @(posedge clk);
      #1;
      cyc++;
      if (c_pop) begin
         check("pop_nonempty", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         pops++;
      end
      if (c_data) begin
         b = bus_q.pop_front();
         data_cnt++;
         if (b.keep && !c_redir) exp_q.push_back('{b.addr, instr_of(b.addr)});
      end
      if (c_acc) begin
         acc_log.push_back(c_addr);
         accepts++;
         if (stale_valid) begin
            check("stale_addr", c_addr, stale_addr);
            stale_valid = 0; keep = 0;
         end else begin
            check("req_addr", c_addr, next_pc);
            next_pc = next_pc + 32'd4; keep = 1;
         end
         bus_q.push_back('{c_addr, keep, cyc});
      end
      if (c_redir) begin
         exp_q.delete();
         foreach (bus_q[i]) bus_q[i].keep = 0;
         next_pc = c_rpc;
         if (c_stay) begin stale_valid = 1; stale_addr = c_addr; end
      end
      check("out_valid", out_valid, (exp_q.size() != 0));
      check("count", count, exp_q.size());
      if (exp_q.size() != 0) begin
         check("out_pc", out_pc, exp_q[0].pc);
         check("out_instr", out_instr, exp_q[0].instr);
      end
      if (c_stay) begin
         check("hold_valid", ireq_valid, 1);
         check("hold_addr", ireq_addr, c_addr);
      end
      check("credit", (int'(count) + bus_q.size() + int'(ireq_valid) <= DEPTH), 1);
   endtask

   task automatic knobs(int ready, int ok, int data, int lat);
      k_ready = ready; k_ok = ok; k_data = data; k_lat = lat;
   endtask

   vec_t vt[8];

   initial begin
      int n, p, d;
      vt[0] = '{0,   100, 20, 4, 0, 4};
      vt[1] = '{100, 100, 1,  3, 1, 4};
      vt[2] = '{0,   100, 10, 4, 0, 5};
      vt[3] = '{100, 0,   2,  2, 1, 5};
      vt[4] = '{0,   100, 10, 4, 0, 7};
      vt[5] = '{100, 0,   10, 0, 1, 7};
      vt[6] = '{0,   100, 10, 4, 0, 11};
      vt[7] = '{100, 100, 1,  3, 1, 11};

      // 1: zero-wait bus, decode always ready
      do_reset();
      knobs(100, 100, 100, 1);
      for (int i = 0; i < 40; i++) begin
         tick();
         check("t1_count_le1", (count <= 1), 1);
      end
      check("t1_acc0", acc_log[0], RESET_PC);
      check("t1_acc3", acc_log[3], RESET_PC + 32'd12);
      check("t1_throughput", (accepts >= 30), 1);

      // 2: phase table, decode stalled / released
      do_reset();
      foreach (vt[v]) begin
         knobs(vt[v].ready, vt[v].ok, 100, 1);
         repeat (vt[v].cycles) tick();
         check($sformatf("t2_count_%0d", v), count, vt[v].exp_count);
         check($sformatf("t2_ivalid_%0d", v), ireq_valid, vt[v].exp_ivalid);
         check($sformatf("t2_acc_%0d", v), accepts, vt[v].exp_acc);
      end

      // 3: addr_ok withheld for 5 cycles on the third request
      do_reset();
      knobs(100, 100, 100, 1);
      n = 0;
      while (accepts < 2 && n < 50) begin tick(); n++; end
      if (accepts < 2) timeout("t3_accepts");
      k_ok = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_ivalid", ireq_valid, 1);
         check("t3_addr", ireq_addr, 32'hbfc0_0008);
      end
      k_ok = 100;
      n = 0;
      while (accepts < 4 && n < 50) begin tick(); n++; end
      if (accepts < 4) timeout("t3_resume");
      else begin
         check("t3_acc2", acc_log[2], 32'hbfc0_0008);
         check("t3_acc3", acc_log[3], 32'hbfc0_000c);
      end

      // 4: redirect with two outstanding and one held
      do_reset();
      knobs(0, 100, 0, 1);
      n = 0;
      while (accepts < 2 && n < 50) begin tick(); n++; end
      if (accepts < 2) timeout("t4_accepts");
      k_ok = 0;
      tick();
      check("t4_held", ireq_valid, 1);
      k_redir_once = 1; k_rpc = 32'h8000_1000;
      tick();
      check("t4_stale_inflight", bus_q.size() + int'(stale_valid), 3);
      knobs(0, 100, 100, 1);
      d = data_cnt; n = 0;
      while (data_cnt - d < 3 && n < 50) begin
         tick(); n++;
         check("t4_no_valid", out_valid, 0);
      end
      if (data_cnt - d < 3) timeout("t4_drain");
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (!out_valid) timeout("t4_refill");
      else check("t4_first_pc", out_pc, 32'h8000_1000);

      // 5: redirect together with data_ok and a pop
      do_reset();
      knobs(0, 100, 100, 1);
      n = 0;
      while (count < 2 && n < 50) begin tick(); n++; end
      if (count < 2) timeout("t5_fill");
      k_data = 0;
      repeat (2) tick();
      knobs(100, 100, 100, 1);
      k_redir_once = 1; k_rpc = 32'h8000_2000;
      p = pops; d = data_cnt;
      tick();
      check("t5_pop", pops - p, 1);
      check("t5_data", data_cnt - d, 1);
      check("t5_count", count, 0);
      check("t5_out_valid", out_valid, 0);
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (!out_valid) timeout("t5_refill");
      else check("t5_first_pc", out_pc, 32'h8000_2000);

      // 6: asynchronous reset mid-HOLD with two entries queued
      do_reset();
      knobs(0, 100, 0, 1);
      n = 0;
      while (accepts < 2 && n < 50) begin tick(); n++; end
      if (accepts < 2) timeout("t6_accepts");
      knobs(0, 0, 100, 1);
      n = 0;
      while (count < 2 && n < 50) begin tick(); n++; end
      if (count < 2) timeout("t6_fill");
      check("t6_ivalid_pre", ireq_valid, 1);
      #2 resetn = 1'b0;
      #1;
      check("t6_ivalid_async", ireq_valid, 0);
      check("t6_count_async", count, 0);
      do_reset();
      knobs(100, 100, 100, 1);
      n = 0;
      while (accepts < 1 && n < 50) begin tick(); n++; end
      if (accepts < 1) timeout("t6_restart");
      else check("t6_first_req", acc_log[0], RESET_PC);

      // 7: randomized traffic with redirects, including near-wrap targets
      do_reset();
      for (int ph = 0; ph < 12; ph++) begin
         knobs($urandom_range(100, 10), $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(4, 1));
         k_redir_prob = 30;
         repeat (250) tick();
      end
      check("rand_progress", (pops > 100), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
